debounce_bank: RTL and testbench
================================

# debounce_bank

Parametrised multi-channel debouncer with edge and long-press detection. Each of `CHANNELS` raw mechanical inputs gets its own two-flop synchroniser, a programmable stability counter, a debounced level, one-cycle press/release pulses and a one-shot long-press pulse. It sits between board pushbuttons/switches and the FIFO control logic, and replaces the single-channel, power-of-two-only debouncer.

## Interface
- `CHANNELS`, 4: number of independent input channels.
- `DB_CYCLES`, 1216000: consecutive stable cycles required to accept a new level (32 ms at 38 MHz); ≥2.
- `HOLD_CYCLES`, 38000000: cycles the debounced level stays high before `long_press` fires; 0 disables long-press.
- `ACTIVE_LOW`, 0: 1 inverts all raw inputs at entry, so every output means "pressed" when high.

- `clk`  in  1  single clock for all logic.
- `n_reset`  in  1  reset, synchronous, active-high (despite the name).
- `button_in`  in  CHANNELS  raw asynchronous inputs.
- `db_out`  out  CHANNELS  debounced level, pressed = 1.
- `press`  out  CHANNELS  one-cycle pulse on a debounced 0→1 change.
- `release`  out  CHANNELS  one-cycle pulse on a debounced 1→0 change.
- `long_press`  out  CHANNELS  one-cycle pulse when a press has lasted `HOLD_CYCLES`.

## Operation
- Channels are fully independent. There is no shared state except `clk`/`n_reset`.
- Entry: `raw = button_in[i] ^ ACTIVE_LOW`. Synchroniser `s1 <= raw`, `s2 <= s1`.
- Stability counter `cnt`, width `$clog2(DB_CYCLES)`. At each edge:
  - `s2 == db_out`: `cnt <= 0`.
  - `s2 != db_out` and `cnt == DB_CYCLES-1`: `db_out <= s2`, `cnt <= 0`, assert `press` (if `s2`=1) or `release` (if `s2`=0) for this one cycle.
  - Otherwise `cnt <= cnt+1`.
- Any bounce back to the current level clears `cnt`, which restarts the stability window.
- If `s2` matches `db_out` on the would-be commit edge, there is no commit and no pulse.
- Hold counter `hcnt`, width `$clog2(HOLD_CYCLES+1)`, saturating:
  - Cleared whenever `db_out`=0.
  - While `db_out`=1 and `hcnt < HOLD_CYCLES`, `hcnt <= hcnt+1`.
  - `long_press` pulses on the edge where `hcnt` becomes `HOLD_CYCLES`.
  - Exactly one pulse per press. Release then re-press re-arms it.
  - With `HOLD_CYCLES`=0, `long_press` is tied 0 and `hcnt` is removed.
- `press`/`release`/`long_press` are registered. `press` and `release` are never both high on one channel.

## Timing
- Reset (`n_reset`=1 at an edge):
  - `s1`, `s2`, `db_out`, `cnt`, `hcnt` go to 0.
  - All pulse outputs go to 0.
  - Nothing is emitted on the reset edge.
- Reset mid-count discards progress. If the input is still pressed after reset deasserts, a fresh `press` follows the normal latency.
- Latency: input stable from before sampling edge 1 → `db_out` and `press`/`release` change at edge `DB_CYCLES+2`.
  - Edges 1–2: synchroniser.
  - Edges 3…`DB_CYCLES+2`: count.
- Long press: commit of the rise at edge E → `long_press` at edge E+`HOLD_CYCLES`.
- Minimum accepted pulse width is `DB_CYCLES` cycles. Shorter glitches are never visible on any output.
- No handshake. Pulses are single-cycle and the consumer must sample every cycle.

## Structure
- Package `debounce_pkg`: `cnt_w(n)` width helper (`$clog2` with a floor of 1) and the default timing constants (`DB_32MS_38MHZ`, `HOLD_1S_38MHZ`).
- Sub-module `debounce_chan`: one channel (synchroniser, `cnt`, `hcnt`, pulse regs), parameters `DB_CYCLES`/`HOLD_CYCLES`/`ACTIVE_LOW`.
- `debounce_bank` is a generate loop of `CHANNELS` instances.

## Test plan
Configuration unless noted: `CHANNELS`=4, `DB_CYCLES`=4, `HOLD_CYCLES`=10, `ACTIVE_LOW`=0.

1. **Reset:** hold `n_reset` 3 cycles with all `button_in`=1 → every output 0 throughout the reset cycles. After deassert, `db_out`=4'hF with `press`=4'hF one cycle at edge 6.
2. **Clean press on ch0:** `button_in[0]` 0→1 before edge 1 → `db_out[0]`=1 and `press[0]`=1 at edge 6 only. Other channels stay silent.
3. **Bounce on ch1:**
   - Stimulus: 1 for 3 cycles, 0 for 1, then 1 held.
   - Required: no output change during the bounce. `press[1]` fires 6 edges after the final 0→1.
   - Also drive a glitch that returns to 0 exactly on the commit edge → no pulse.
4. **Long press on ch2:** held high → `press[2]` at E, `long_press[2]` single pulse at E+10, none after. Release → `release[2]` at 6 edges after the fall, `long_press` stays 0. Re-press → a second long-press.
5. **Active-low instance:**
   - Idle `button_in`=4'hF → all outputs 0.
   - Drive ch3 low → `press[3]` at edge 6.
   - Drive ch3 high again → `release[3]` 6 edges later.
6. **Reset mid-operation:**
   - Reset asserted with `cnt`=3 on ch0 and `hcnt`=7 on ch2 → no `press`/`long_press` is emitted.
   - Inputs held through reset → `press` 6 edges after deassert, and `long_press` 10 edges after that.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the multi-channel pushbutton debouncer.
package debounce_pkg;

  // Default timing for a 38 MHz clock.
  localparam int unsigned DB_32MS_38MHZ = 32'd1_216_000;
  localparam int unsigned HOLD_1S_38MHZ = 32'd38_000_000;

  // Counter width for a range of n values. Never returns less than 1 bit,
  // so degenerate ranges still produce a legal vector.
  function automatic int cnt_w(input int unsigned n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debouncer channel: two-flop synchroniser, stability counter, debounced
// level with press/release pulses, and a one-shot long-press detector.
// The release pulse is named "released" because "release" is a reserved word.
// DB_CYCLES must be at least 2.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int unsigned DB_CYCLES   = DB_32MS_38MHZ,
  parameter int unsigned HOLD_CYCLES = HOLD_1S_38MHZ,
  parameter bit          ACTIVE_LOW  = 1'b0
) (
  input  logic clk,
  input  logic n_reset,
  input  logic button_in,
  output logic db_out,
  output logic press,
  output logic released,
  output logic long_press
);

  localparam int CW = cnt_w(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          raw;
  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // Normalise polarity so that 1 always means "pressed" downstream.
  assign raw = button_in ^ ACTIVE_LOW;

  // Two-flop synchroniser for the asynchronous pin.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make s2 take the old s1, forming a real
    // two-stage chain; blocking ones would collapse it into a single flop.
    if (n_reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Stability window: commit a new level after DB_CYCLES consecutive
  // disagreeing samples; any return to the current level restarts it.
  always_ff @(posedge clk) begin
    if (n_reset) begin
      cnt      <= '0;
      db_out   <= 1'b0;
      press    <= 1'b0;
      released <= 1'b0;
    end else begin
      // NOTE: pulses default low every cycle, so a commit yields exactly one
      // cycle of press or release without any separate clearing logic.
      press    <= 1'b0;
      released <= 1'b0;
      if (s2 == db_out) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        db_out   <= s2;
        cnt      <= '0;
        press    <= s2;
        released <= ~s2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  if (HOLD_CYCLES > 0) begin : g_hold
    localparam int HW = cnt_w(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_PRE = HW'(HOLD_CYCLES - 1);

    logic [HW-1:0] hcnt;

    // Saturating hold timer; fires once on the edge it reaches HOLD_CYCLES,
    // and re-arms only when the debounced level drops.
    always_ff @(posedge clk) begin
      if (n_reset) begin
        hcnt       <= '0;
        long_press <= 1'b0;
      end else begin
        long_press <= db_out && (hcnt == HOLD_PRE);
        if (!db_out) begin
          hcnt <= '0;
        end else if (hcnt < HOLD_MAX) begin
          hcnt <= hcnt + HW'(1);
        end
      end
    end
  end else begin : g_no_hold
    assign long_press = 1'b0;
  end

endmodule

// File: rtl/debounce_bank.sv
// Bank of independent pushbutton debouncers sharing only clock and reset.
// The release pulse vector is named "released" because "release" is a
// reserved word.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned DB_CYCLES   = DB_32MS_38MHZ,
  parameter int unsigned HOLD_CYCLES = HOLD_1S_38MHZ,
  parameter bit          ACTIVE_LOW  = 1'b0
) (
  input  logic                clk,
  input  logic                n_reset,
  input  logic [CHANNELS-1:0] button_in,
  output logic [CHANNELS-1:0] db_out,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] released,
  output logic [CHANNELS-1:0] long_press
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    debounce_chan #(
      .DB_CYCLES  (DB_CYCLES),
      .HOLD_CYCLES(HOLD_CYCLES),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_chan (
      .clk       (clk),
      .n_reset   (n_reset),
      .button_in (button_in[i]),
      .db_out    (db_out[i]),
      .press     (press[i]),
      .released  (released[i]),
      .long_press(long_press[i])
    );
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank: an active-high and an active-low instance
// (DB_CYCLES=4, HOLD_CYCLES=10) share clock and reset. Expected outputs are
// packed as {db_out, press, released, long_press}.
module tb_debounce_bank;

  logic       clk = 1'b0;
  logic       n_reset;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] db_m, pr_m, rl_m, lp_m;
  logic [3:0] db_a, pr_a, rl_a, lp_a;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  debounce_bank #(
    .CHANNELS(4), .DB_CYCLES(4), .HOLD_CYCLES(10), .ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .n_reset(n_reset), .button_in(a),
    .db_out(db_m), .press(pr_m), .released(rl_m), .long_press(lp_m)
  );

  debounce_bank #(
    .CHANNELS(4), .DB_CYCLES(4), .HOLD_CYCLES(10), .ACTIVE_LOW(1'b1)
  ) dut_al (
    .clk(clk), .n_reset(n_reset), .button_in(b),
    .db_out(db_a), .press(pr_a), .released(rl_a), .long_press(lp_a)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance n edges, checking both instances 1 time unit after each edge.
  task automatic run(input string tag, input int n, input logic [15:0] em, input logic [15:0] ea);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("%s.main[%0d]", tag, i), {db_m, pr_m, rl_m, lp_m}, em);
      check($sformatf("%s.al[%0d]", tag, i), {db_a, pr_a, rl_a, lp_a}, ea);
    end
  endtask

  task automatic do_reset();
    n_reset = 1'b1;
    a = 4'h0;
    b = 4'hF;
    run("rst", 2, 16'h0000, 16'h0000);
    n_reset = 1'b0;
  endtask

  initial begin
    // 1: reset with all main inputs pressed, then press on every channel
    n_reset = 1'b1;
    a = 4'hF;
    b = 4'hF;
    run("t1_rst", 3, 16'h0000, 16'h0000);
    n_reset = 1'b0;
    run("t1_wait", 5, 16'h0000, 16'h0000);
    run("t1_press", 1, 16'hFF00, 16'h0000);
    run("t1_held", 1, 16'hF000, 16'h0000);
    do_reset();

    // 2: clean press on ch0
    a = 4'h1;
    run("t2_wait", 5, 16'h0000, 16'h0000);
    run("t2_press", 1, 16'h1100, 16'h0000);
    run("t2_held", 2, 16'h1000, 16'h0000);
    do_reset();

    // 3a: bounce on ch1 (1,1,1,0, then 1 held) -> press 6 edges after last rise
    a = 4'h2;
    run("t3_hi", 3, 16'h0000, 16'h0000);
    a = 4'h0;
    run("t3_lo", 1, 16'h0000, 16'h0000);
    a = 4'h2;
    run("t3_wait", 5, 16'h0000, 16'h0000);
    run("t3_press", 1, 16'h2200, 16'h0000);
    run("t3_held", 1, 16'h2000, 16'h0000);
    do_reset();

    // 3b: glitch that drops back exactly on the would-be commit edge
    a = 4'h2;
    run("t3g_hi", 3, 16'h0000, 16'h0000);
    a = 4'h0;
    run("t3g_quiet", 8, 16'h0000, 16'h0000);
    do_reset();

    // 4: long press on ch2, release, re-press
    a = 4'h4;
    run("t4_wait", 5, 16'h0000, 16'h0000);
    run("t4_press", 1, 16'h4400, 16'h0000);
    run("t4_hold", 9, 16'h4000, 16'h0000);
    run("t4_long", 1, 16'h4004, 16'h0000);
    run("t4_after", 4, 16'h4000, 16'h0000);
    a = 4'h0;
    run("t4_rwait", 5, 16'h4000, 16'h0000);
    run("t4_release", 1, 16'h0040, 16'h0000);
    run("t4_idle", 1, 16'h0000, 16'h0000);
    a = 4'h4;
    run("t4_wait2", 5, 16'h0000, 16'h0000);
    run("t4_press2", 1, 16'h4400, 16'h0000);
    run("t4_hold2", 9, 16'h4000, 16'h0000);
    run("t4_long2", 1, 16'h4004, 16'h0000);
    run("t4_after2", 2, 16'h4000, 16'h0000);
    do_reset();

    // 5: active-low instance, ch3 pulled low then released
    b = 4'h7;
    run("t5_wait", 5, 16'h0000, 16'h0000);
    run("t5_press", 1, 16'h0000, 16'h8800);
    run("t5_held", 1, 16'h0000, 16'h8000);
    b = 4'hF;
    run("t5_rwait", 5, 16'h0000, 16'h8000);
    run("t5_release", 1, 16'h0000, 16'h0080);
    run("t5_idle", 1, 16'h0000, 16'h0000);
    do_reset();

    // 6: reset with ch0 cnt=3 and ch2 hcnt=7, inputs held through reset
    a = 4'h4;
    run("t6_wait", 5, 16'h0000, 16'h0000);
    run("t6_press", 1, 16'h4400, 16'h0000);
    run("t6_hold", 2, 16'h4000, 16'h0000);
    a = 4'h5;
    run("t6_count", 5, 16'h4000, 16'h0000);
    n_reset = 1'b1;
    run("t6_rst", 2, 16'h0000, 16'h0000);
    n_reset = 1'b0;
    run("t6_wait2", 5, 16'h0000, 16'h0000);
    run("t6_press2", 1, 16'h5500, 16'h0000);
    run("t6_hold2", 9, 16'h5000, 16'h0000);
    run("t6_long", 1, 16'h5005, 16'h0000);
    run("t6_after", 2, 16'h5000, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
